toffoli_share_encoder: RTL and testbench
========================================

Name: toffoli_share_encoder

Overview:
- Input stage directly upstream of the 2-share masked Toffoli gate.
- Takes unmasked a/b/c bits plus fresh randomness and produces Boolean 2-share encodings. Every share leaves the block straight from a flop, with no combinational logic on the output path.
- Buffers encodings in a 2-entry FIFO behind a valid/ready handshake, so the Toffoli pipeline is fed one fresh encoding per cycle.
- Counts issued encodings for bench and verification bookkeeping.

Parameters:
- WIDTH, 1, number of parallel Toffoli lanes (bits per a/b/c operand).
- CNT_W, 16, width of the issued-encoding counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a/b/c hold a valid unmasked operand.
- in_ready  out  1  block accepts an operand this cycle.
- a  in  WIDTH  unmasked operand a.
- b  in  WIDTH  unmasked operand b.
- c  in  WIDTH  unmasked operand c.
- rnd_valid  in  1  rnd holds fresh randomness.
- rnd  in  3*WIDTH  randomness, laid out as {r_c, r_b, r_a}; each field is WIDTH bits.
- rnd_ready  out  1  rnd is consumed this cycle.
- out_valid  out  1  head encoding valid.
- out_ready  in  1  downstream takes the head encoding.
- a_sh  out  2*WIDTH  shares of a; lane j occupies bits [2j+1:2j], share0 at bit 2j, share1 at bit 2j+1.
- b_sh  out  2*WIDTH  shares of b, same layout as a_sh.
- c_sh  out  2*WIDTH  shares of c, same layout as a_sh.
- enc_cnt  out  CNT_W  number of encodings accepted since reset.

Behaviour:
- Acceptance: accept = in_valid & rnd_valid & in_ready.
  - rnd_ready = in_valid & in_ready; randomness is consumed only when an operand is present and can be accepted.
  - If rnd_valid=0, nothing is accepted; the operand waits.
- Encoding per lane j, for x in {a, b, c}:
  - share0 = x[j] ^ r_x[j]
  - share1 = r_x[j]
  - Each randomness bit is used exactly once; the block never reuses masks across accepts or lanes.
- Encoding is computed combinationally at the FIFO write port and stored. The FIFO entry is the only state holding shares. Outputs come from the head entry registers through a register-select mux only; no logic mixes share0 and share1 after storage.
- FIFO structure: 2 entries, occupancy count 0..2, separate read and write pointers, 1 bit each.
  - in_ready = (count != 2). It is derived from registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - pop = out_valid & out_ready.
  - push = accept.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; write-then-read order is preserved, so a push into an empty FIFO is never popped in the same cycle.
- Latency: an accept in cycle t gives out_valid=1 in cycle t+1 with that encoding at the head, when the FIFO was empty.
- Full: count=2 and out_ready=1 still gives in_ready=0 that cycle; in_ready=1 the next cycle. Throughput is therefore 1/cycle at count ≤ 1.
- Stall: while out_valid=1 and out_ready=0, the head shares and out_valid stay stable.
- Empty: a_sh, b_sh and c_sh show the last-popped entry's contents. They are don't-care but must not change while out_valid=0 unless a push occurs.
- enc_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Reset, including mid-operation:
  - count=0, pointers=0, out_valid=0.
  - in_ready=0 during the reset cycle, 1 afterwards.
  - rnd_ready=0 during the reset cycle.
  - All FIFO entries and a_sh/b_sh/c_sh = 0.
  - enc_cnt=0.
  - In-flight entries are discarded; an accept in the reset cycle is ignored.

Test Plan:
- Reset, then a=1, b=1, c=0, rnd={r_c=1, r_b=0, r_a=1}, both valids high for one cycle, out_ready=1 → next cycle out_valid=1, a_sh=2'b10, b_sh=2'b01, c_sh=2'b11, enc_cnt=1.
- Stream 8 operands with in_valid, rnd_valid and out_ready held at 1 → one output per cycle, in order. For every lane, share0^share1 equals the input. enc_cnt=8. in_ready stays 1.
- out_ready=0, push 3 operands → in_ready=0 after 2 accepts and the third waits. Raise out_ready → entry 1 pops; in_ready goes to 1 one cycle later; the third operand is accepted and order is preserved.
- in_valid=1 with rnd_valid=0 for 3 cycles → rnd_ready=1 while in_ready=1, no accept, enc_cnt unchanged, out_valid stays 0. Then rnd_valid=1 → accept.
- Fill the FIFO to 2, then assert rst for one cycle → out_valid=0, all shares 0, enc_cnt=0, in_ready=0 in the reset cycle and 1 after it; the prior entries never appear.
- CNT_W=4: 17 accepts → enc_cnt wraps 15→0 and reads 1 at the end.

Source files
------------

// File: rtl/toffoli_share_encoder.sv
// toffoli_share_encoder
//   Input stage for the 2-share masked Toffoli gate. Splits unmasked a/b/c
//   lanes into Boolean share pairs using fresh randomness and buffers the
//   encodings in a 2-entry FIFO behind a valid/ready handshake.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, c: WIDTH bits each)
//   rnd_valid/rnd_ready randomness handshake (rnd = {r_c, r_b, r_a})
//   out_valid/out_ready encoding handshake (a_sh/b_sh/c_sh: lane j at
//                     bits [2j+1:2j], share0 at 2j, share1 at 2j+1)
//   enc_cnt           encodings accepted since reset (wraps)
module toffoli_share_encoder #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic               rnd_valid,
  input  logic [3*WIDTH-1:0] rnd,
  output logic               rnd_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] a_sh,
  output logic [2*WIDTH-1:0] b_sh,
  output logic [2*WIDTH-1:0] c_sh,
  output logic [CNT_W-1:0]   enc_cnt
);

  localparam int unsigned EW = 6 * WIDTH;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic             rd_sel;
  logic [EW-1:0]    mem_q [2];
  logic [CNT_W-1:0] enc_cnt_q;

  logic             push, pop;
  logic [2*WIDTH-1:0] enc_a, enc_b, enc_c;

  // in_ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready  = ~rst & (count_q != 2'd2);
  assign rnd_ready = in_valid & in_ready;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & rnd_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Share split at the FIFO write port: share0 = x ^ r, share1 = r.
  always_comb begin
    enc_a = '0;
    enc_b = '0;
    enc_c = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      enc_a[2*j]   = a[j] ^ rnd[j];
      enc_a[2*j+1] = rnd[j];
      enc_b[2*j]   = b[j] ^ rnd[WIDTH+j];
      enc_b[2*j+1] = rnd[WIDTH+j];
      enc_c[2*j]   = c[j] ^ rnd[2*WIDTH+j];
      enc_c[2*j+1] = rnd[2*WIDTH+j];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      enc_cnt_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {enc_a, enc_b, enc_c};
        wr_ptr_q        <= ~wr_ptr_q;
        enc_cnt_q       <= enc_cnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // When empty, rd_ptr already points at the next write slot; selecting the
  // other entry keeps the last-popped encoding visible until a new one lands.
  assign rd_sel = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;

  assign a_sh    = mem_q[rd_sel][EW-1 -: 2*WIDTH];
  assign b_sh    = mem_q[rd_sel][4*WIDTH-1 -: 2*WIDTH];
  assign c_sh    = mem_q[rd_sel][2*WIDTH-1 -: 2*WIDTH];
  assign enc_cnt = enc_cnt_q;

endmodule

// File: tb/tb_toffoli_share_encoder.sv
// Scoreboard bench for toffoli_share_encoder (WIDTH=1, CNT_W=4).
module tb_toffoli_share_encoder;

  logic       clk, rst;
  logic       in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
  logic [0:0] a, b, c;
  logic [2:0] rnd;
  logic [1:0] a_sh, b_sh, c_sh;
  logic [3:0] enc_cnt;

  toffoli_share_encoder #(.WIDTH(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c),
    .rnd_valid(rnd_valid), .rnd(rnd), .rnd_ready(rnd_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_sh(a_sh), .b_sh(b_sh), .c_sh(c_sh),
    .enc_cnt(enc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: {a,b,c}, {r_c,r_b,r_a}, expected {a_sh,b_sh,c_sh}.
  logic [2:0] vx [9] = '{3'b110, 3'b000, 3'b100, 3'b010, 3'b001,
                         3'b111, 3'b101, 3'b011, 3'b110};
  logic [2:0] vr [9] = '{3'b101, 3'b000, 3'b000, 3'b001, 3'b010,
                         3'b111, 3'b100, 3'b011, 3'b110};
  logic [5:0] ve [9] = '{6'b10_01_11, 6'b00_00_00, 6'b01_00_00, 6'b11_01_00,
                         6'b00_11_01, 6'b10_10_10, 6'b01_00_10, 6'b11_10_01,
                         6'b01_10_11};

  typedef struct {
    logic [5:0] sh;
    logic [2:0] x;
  } exp_t;

  exp_t       sb [$];
  int         n_checks = 0;
  int         n_err = 0;
  int         m_cnt = 0;
  logic [3:0] exp_cnt = '0;
  logic [5:0] cur_exp = '0;
  logic [2:0] cur_x = '0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Occupancy/handshake model and scoreboard push on each accept.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_rst", in_ready, 0);
      chk("rnd_ready_rst", rnd_ready, 0);
      sb.delete();
      m_cnt   = 0;
      exp_cnt = '0;
    end else begin
      automatic bit acc, pp;
      chk("in_ready", in_ready, m_cnt != 2);
      chk("rnd_ready", rnd_ready, in_valid && m_cnt != 2);
      chk("out_valid", out_valid, m_cnt != 0);
      chk("enc_cnt", enc_cnt, exp_cnt);
      acc = in_valid && rnd_valid && m_cnt != 2;
      pp  = (m_cnt != 0) && out_ready;
      if (acc) begin
        exp_t e;
        e.sh = cur_exp;
        e.x  = cur_x;
        sb.push_back(e);
        exp_cnt = exp_cnt + 4'd1;
      end
      m_cnt = m_cnt + int'(acc) - int'(pp);
    end
  end

  // Output monitor: head must match scoreboard front while valid.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {a_sh, b_sh, c_sh}, 0);
        n_err++;
        $display("FAIL sb_empty: output present with no expected entry");
      end else begin
        chk("shares", {a_sh, b_sh, c_sh}, sb[0].sh);
        chk("share_xor", {a_sh[1] ^ a_sh[0], b_sh[1] ^ b_sh[0], c_sh[1] ^ c_sh[0]},
            sb[0].x);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int k);
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    {a, b, c} = vx[k];
    rnd       = vr[k];
    cur_x     = vx[k];
    cur_exp   = ve[k];
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
  endtask

  // Present vector k and wait (bounded) until it is accepted.
  task automatic send(input int k);
    drive_vec(k);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        return;
      end
      step();
    end
    n_err++;
    $display("FAIL send_timeout: vector %0d not accepted", k);
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!out_valid) begin
        step();
        return;
      end
      step();
    end
    n_err++;
    $display("FAIL drain_timeout: out_valid stuck high");
  endtask

  initial begin
    logic [3:0] cnt_before;
    rst = 1'b1; out_ready = 1'b1;
    drive_vec(0);                      // accept attempt during reset is ignored
    step(); step();
    rst = 1'b0; idle();
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_shares", {a_sh, b_sh, c_sh}, 0);
    chk("post_rst_enc_cnt", enc_cnt, 0);
    chk("post_rst_in_ready", in_ready, 1);
    step();

    // Single encoding, one-cycle latency.
    send(0); idle();
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_enc_cnt", enc_cnt, 1);
    step();

    // Back-to-back stream of 8.
    for (int k = 1; k <= 8; k++) send(k);
    idle();
    drain();
    chk("stream_enc_cnt", enc_cnt, 9);
    chk("empty_holds_last", {a_sh, b_sh, c_sh}, ve[8]);

    // Full FIFO back-pressure, third operand waits.
    out_ready = 1'b0;
    send(1); send(2); drive_vec(3);
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", in_ready, 0);
    step();
    send(3); idle();
    drain();

    // Operand waiting on randomness.
    cnt_before = enc_cnt;
    drive_vec(4); rnd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("norand_rnd_ready", rnd_ready, 1);
      chk("norand_out_valid", out_valid, 0);
      step();
    end
    chk("norand_enc_cnt", enc_cnt, cnt_before);
    send(4); idle();
    drain();

    // Reset with a full FIFO.
    out_ready = 1'b0;
    send(5); send(6); idle();
    rst = 1'b1; drive_vec(7);
    step();
    rst = 1'b0; idle();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_shares", {a_sh, b_sh, c_sh}, 0);
    chk("midrst_enc_cnt", enc_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // Counter wrap: 17 accepts on a 4-bit counter.
    for (int i = 0; i < 17; i++) send(i % 9);
    idle();
    drain();
    chk("wrap_enc_cnt", enc_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
